// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver and the receive FIFO.
package uart_pkg;
    localparam int NUM_DATA_BITS = 8;
    localparam int CLKS_PER_BIT  = 87;
endpackage

// File: rtl/fifo_mem.sv
// Storage array for the receive FIFO.
// It has a synchronous write port and an asynchronous read port. The contents are not reset.
module fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_wrEn,
    input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]         i_wrData,
    input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
    output logic [WIDTH-1:0]         o_rdData
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = mem[i_rdAddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO behind the UART receiver.
// One word is written per rising edge of the receive-complete flag. A word that arrives while the FIFO is full sets a sticky overrun flag.
module uart_rx_fifo #(
    parameter int NUM_DATA_BITS = uart_pkg::NUM_DATA_BITS,
    parameter int DEPTH         = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_rxcFlag,
    input  logic [NUM_DATA_BITS-1:0]   i_rxByte,
    input  logic                       i_rdReady,
    output logic                       o_rdValid,
    output logic [NUM_DATA_BITS-1:0]   o_rdData,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    input  logic                       i_clrOverrun,
    output logic                       o_overrun
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic             rxcFlag_p1;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             overrun;
    logic             wrStrobe;
    logic             rdFire;
    logic             wrEn;

    assign o_count   = count;
    assign o_empty   = (count == '0);
    assign o_full    = (count == FULL_CNT);
    assign o_rdValid = !o_empty;
    assign o_overrun = overrun;

    assign wrStrobe = i_rxcFlag && !rxcFlag_p1;
    assign rdFire   = o_rdValid && i_rdReady;
    // When the FIFO is full, a read in the same cycle frees the slot the write lands in.
    assign wrEn     = wrStrobe && (!o_full || rdFire);

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (NUM_DATA_BITS)
    ) u_mem (
        .i_clk    (i_clk),
        .i_wrEn   (wrEn),
        .i_wrAddr (wrPtr),
        .i_wrData (i_rxByte),
        .i_rdAddr (rdPtr),
        .o_rdData (o_rdData)
    );

    // Edge-detect stage: reset high so a flag already high at reset release is ignored
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rxcFlag_p1 <= 1'b1;
        end else begin
            rxcFlag_p1 <= i_rxcFlag;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (rdFire) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({wrEn, rdFire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wrStrobe && o_full && !rdFire) begin
                overrun <= 1'b1;
            end else if (i_clrOverrun) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed writes push expected words; a monitor pops on each read handshake.
module tb_uart_rx_fifo;
    logic       clk;
    logic       rst_n;
    logic       rxcFlag;
    logic [7:0] rxByte;
    logic       rdReady;
    logic       rdValid;
    logic [7:0] rdData;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       clrOverrun;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    logic [7:0] expQ [$];

    uart_rx_fifo #(.NUM_DATA_BITS(8), .DEPTH(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rxcFlag    (rxcFlag),
        .i_rxByte     (rxByte),
        .i_rdReady    (rdReady),
        .o_rdValid    (rdValid),
        .o_rdData     (rdData),
        .o_count      (count),
        .o_full       (full),
        .o_empty      (empty),
        .i_clrOverrun (clrOverrun),
        .o_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [7:0] b, input bit expectStored);
        rxcFlag = 1'b1;
        rxByte  = b;
        if (expectStored) expQ.push_back(b);
        tick();
        rxcFlag = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        rdReady = 1'b1;
        repeat (n) tick();
        rdReady = 1'b0;
    endtask

    // Monitor: every read handshake must return the oldest expected word
    always @(negedge clk) begin
        if (rst_n && rdValid && rdReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdData: got 0x%0h, expected no word", rdData);
            end else begin
                check("rdData", rdData, expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rxcFlag = 1'b0; rxByte = 8'h00; rdReady = 1'b0; clrOverrun = 1'b0;
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", rdValid, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        // Single word, one-cycle flag pulse
        rxcFlag = 1'b1; rxByte = 8'hA5; expQ.push_back(8'hA5);
        tick();
        check("single_valid", rdValid, 1);
        check("single_data", rdData, 8'hA5);
        check("single_count", count, 1);
        rxcFlag = 1'b0;
        tick();
        drain(1);
        check("single_empty", empty, 1);

        // A read request while empty has no effect
        drain(2);
        check("empty_rd_count", count, 0);

        // A flag held high for 5 cycles writes exactly once
        rxcFlag = 1'b1; rxByte = 8'h3C; expQ.push_back(8'h3C);
        repeat (5) tick();
        rxcFlag = 1'b0;
        tick();
        check("long_count", count, 1);
        drain(1);

        // Fill to full, then overrun
        for (int i = 0; i < 16; i++) writeWord(8'(i), 1'b1);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_ovr_pre", overrun, 0);
        writeWord(8'h10, 1'b0);
        check("ovr_set", overrun, 1);
        check("ovr_count", count, 16);
        // A new overrun coincides with a clear: the set wins
        rxcFlag = 1'b1; rxByte = 8'h11; clrOverrun = 1'b1;
        tick();
        rxcFlag = 1'b0; clrOverrun = 1'b0;
        check("ovr_setwins", overrun, 1);
        tick();
        drain(16);
        check("drain_empty", empty, 1);
        check("ovr_sticky", overrun, 1);
        clrOverrun = 1'b1;
        tick();
        clrOverrun = 1'b0;
        check("ovr_clr", overrun, 0);

        // Full plus a simultaneous read and write
        for (int i = 0; i < 16; i++) writeWord(8'h20 + 8'(i), 1'b1);
        rxcFlag = 1'b1; rxByte = 8'h55; rdReady = 1'b1; expQ.push_back(8'h55);
        tick();
        rxcFlag = 1'b0; rdReady = 1'b0;
        check("simul_count", count, 16);
        tick();
        check("simul_ovr", overrun, 0);
        drain(16);
        check("simul_empty", empty, 1);

        // Wrap-around: write and read together, at most 6 words stored
        for (int i = 0; i < 40; i++) begin
            rxcFlag = 1'b1; rxByte = 8'h80 + 8'(i); expQ.push_back(8'h80 + 8'(i));
            rdReady = (i >= 5);
            tick();
            rxcFlag = 1'b0; rdReady = 1'b0;
            tick();
        end
        check("wrap_count", count, 5);
        drain(5);
        check("wrap_empty", empty, 1);

        // Reset asserted mid-stream clears the FIFO without waiting for a clock edge
        for (int i = 0; i < 7; i++) writeWord(8'hC0 + 8'(i), 1'b1);
        check("pre_rst_count", count, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_valid", rdValid, 0);
        expQ.delete();
        rxcFlag = 1'b1; rxByte = 8'hEE;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rel_flag_count", count, 0);
        rxcFlag = 1'b0;
        tick();
        writeWord(8'h77, 1'b1);
        check("post_rst_count", count, 1);
        drain(1);

        check("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter NUM_DATA_BITS, default 8, SHALL set the width of one received word.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of storage entries; legal values are powers of two, 2 to 256.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 i_rxcFlag  input  1  SHALL be the receive-complete flag from the upstream UART receiver.
REQ-007 i_rxByte  input  NUM_DATA_BITS  SHALL be the received word, valid while i_rxcFlag is high.
REQ-008 i_rdReady  input  1  SHALL be the consumer acceptance signal.
REQ-009 o_rdValid  output  1  SHALL indicate that o_rdData holds the oldest stored word.
REQ-010 o_rdData  output  NUM_DATA_BITS  SHALL be the oldest stored word (first-word fall-through).
REQ-011 o_count  output  $clog2(DEPTH)+1  SHALL be the number of stored words.
REQ-012 o_full / o_empty  output  1 each  SHALL report count==DEPTH and count==0.
REQ-013 i_clrOverrun  input  1  SHALL clear the sticky overrun flag.
REQ-014 o_overrun  output  1  SHALL be the sticky flag for a word dropped while full.

Function
REQ-015 Write strobe SHALL be the rising edge of i_rxcFlag (i_rxcFlag high, previous-cycle sample low), so one write per received word regardless of pulse length.
REQ-016 On a write strobe with space available, i_rxByte SHALL be stored at the write pointer, and the pointer SHALL advance modulo DEPTH.
REQ-017 Read handshake SHALL complete on a cycle with o_rdValid and i_rdReady both high; the read pointer SHALL then advance modulo DEPTH.
REQ-018 o_rdValid SHALL equal not-empty; with i_rdReady low, o_rdData SHALL hold its value.
REQ-019 Write-to-read latency: o_rdValid and o_rdData SHALL be valid from the clock edge that samples the write strobe, i.e. one cycle after i_rxcFlag rises into an empty FIFO.
REQ-020 Count rules:
- write only: +1
- read only: -1
- both in the same cycle: unchanged
REQ-021 If full and a read handshake coincide with a write strobe, the write SHALL be accepted; count stays DEPTH and there is no overrun.
REQ-022 A write strobe while full with no read SHALL drop the word, leave all storage and pointers unchanged, and set o_overrun on the next edge.
REQ-023 o_overrun SHALL stay high until a cycle with i_clrOverrun high; if a new overrun coincides with i_clrOverrun, set SHALL win.
REQ-024 i_rdReady while empty SHALL have no effect.
REQ-025 Pointers SHALL be log2(DEPTH) bits and wrap naturally; full/empty SHALL derive from o_count, not pointer comparison.

Reset
REQ-026 While i_rst_n is low, the block SHALL hold:
- pointers and o_count at 0
- o_empty=1, o_full=0, o_rdValid=0, o_overrun=0
REQ-027 The i_rxcFlag previous-sample register SHALL reset to 1, so a flag already high at reset release does not cause a write.
REQ-028 Storage contents SHALL NOT be reset; o_rdData is don't-care while o_rdValid=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored words immediately (asynchronous).

Structure
REQ-030 A shared package uart_pkg SHALL hold NUM_DATA_BITS and the default CLKS_PER_BIT, common to UART_Rx and this block.
REQ-031 Storage SHALL be a sub-module fifo_mem: DEPTH x NUM_DATA_BITS, synchronous write, asynchronous read, no reset.
REQ-032 Edge detection, pointers, count and flags SHALL live in uart_rx_fifo.

Verification
REQ-033 Single word: reset, then one 1-cycle i_rxcFlag pulse with 0xA5 -> next cycle o_rdValid=1, o_rdData=0xA5, o_count=1; i_rdReady pulse -> o_empty=1.
REQ-034 Long pulse: i_rxcFlag held high 5 cycles with 0x3C -> exactly one write, o_count=1.
REQ-035 Fill and overrun (DEPTH=16): write 0x00..0x0F, then 0x10 -> o_full=1, o_overrun=1; reads return 0x00..0x0F in order and 0x10 is never output; i_clrOverrun -> o_overrun=0.
REQ-036 Full plus simultaneous read/write: full, i_rdReady=1 and write 0x55 in the same cycle -> o_count stays 16, o_overrun=0, 0x55 read last.
REQ-037 Wrap-around: 40 writes interleaved with reads, never more than 10 stored -> output order matches input order.
REQ-038 Reset: assert i_rst_n=0 mid-stream with o_count=7 -> o_count=0 and o_rdValid=0 without a clock edge; release with i_rxcFlag=1 -> no write.
